// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file: clear-FSM state
// encoding and the byte-lane merge used by both the write path and the bypass.
package reg_file_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       be
    );
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// Background clear sequencer: walks every entry once, one per clock,
// raising busy for exactly 2**W cycles.
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         clr_req,
    output logic         busy,
    output logic         clr_we,
    output logic [W-1:0] clr_addr
);

    clr_state_e   state;
    clr_state_e   state_nxt;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                // Counter wrap back to zero coincides with the last entry.
                cnt_nxt = cnt + 1'b1;
                if (&cnt) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy     = (state == ST_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_mp.sv
// 2**W x B register file with NR combinational read ports, two byte-enabled
// write ports (w1 has priority), optional bypass/zero register and background clear.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int W        = 5,
    parameter int B        = 8,
    parameter int NR       = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic [NR*W-1:0] r_addr,
    output logic [NR*B-1:0] r_data,
    input  logic            w0_en,
    input  logic [W-1:0]    w0_addr,
    input  logic [B-1:0]    w0_data,
    input  logic [B/8-1:0]  w0_be,
    input  logic            w1_en,
    input  logic [W-1:0]    w1_addr,
    input  logic [B-1:0]    w1_data,
    input  logic [B/8-1:0]  w1_be,
    input  logic            clr_req,
    output logic            busy
);

    localparam int N    = 2 ** W;
    localparam int BE_W = B / 8;

    logic [B-1:0] mem     [N];
    logic [B-1:0] mem_nxt [N];
    logic         clr_we;
    logic [W-1:0] clr_addr;

    function automatic logic [B-1:0] merge_entry(
        input logic [B-1:0]    old_v,
        input logic [B-1:0]    new_v,
        input logic [BE_W-1:0] be
    );
        logic [B-1:0] res;
        for (int j = 0; j < BE_W; j++) begin
            res[8*j +: 8] = byte_merge(old_v[8*j +: 8], new_v[8*j +: 8], be[j]);
        end
        return res;
    endfunction

    reg_file_clr_seq #(
        .W (W)
    ) u_clr_seq (
        .clk      (clk),
        .n_reset  (n_reset),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Post-edge contents; also the source for same-cycle bypass reads.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            mem_nxt[i] = mem[i];
            if (clr_we) begin
                if (clr_addr == W'(i)) begin
                    mem_nxt[i] = '0;
                end
            end else begin
                if (w0_en && (w0_addr == W'(i))) begin
                    mem_nxt[i] = merge_entry(mem_nxt[i], w0_data, w0_be);
                end
                if (w1_en && (w1_addr == W'(i))) begin
                    mem_nxt[i] = merge_entry(mem_nxt[i], w1_data, w1_be);
                end
            end
            if ((ZERO_REG != 0) && (i == 0)) begin
                mem_nxt[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= mem_nxt[i];
            end
        end
    end

    always_comb begin
        r_data = '0;
        for (int k = 0; k < NR; k++) begin
            if ((ZERO_REG != 0) && (r_addr[k*W +: W] == '0)) begin
                r_data[k*B +: B] = '0;
            end else if ((BYPASS != 0) && !busy) begin
                r_data[k*B +: B] = mem_nxt[r_addr[k*W +: W]];
            end else begin
                r_data[k*B +: B] = mem[r_addr[k*W +: W]];
            end
        end
    end

endmodule
